// File: rtl/tp_pulse_stretcher_if.sv
// Avalon-MM register bus for the test-point pulse stretcher.
interface tp_pulse_stretcher_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/tp_pulse_stretcher.sv
// Test-point pulse stretcher: widens rising edges on masked channels to LEN cycles.
// Optional per-channel rising-edge counters enabled by macro TP_STRETCH_EVCNT_EN.
module tp_ch #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_bit,
  input  logic             in_d,
  input  logic             mask,
  input  logic [LEN_W-1:0] len,
  output logic             tp_q
);
  localparam logic [LEN_W-1:0] ONE = 1;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             tp_d, rise;

  assign rise = in_bit & ~in_d;

  always_comb begin
    cnt_d = cnt_q;
    if (rise && mask)        cnt_d = (len == '0) ? '0 : len - ONE;
    else if (cnt_q != '0)    cnt_d = cnt_q - ONE;
    tp_d = mask ? (in_bit | (cnt_q != '0)) : in_bit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      tp_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tp_q  <= tp_d;
    end
  end
endmodule

module tp_pulse_stretcher #(
  parameter int WIDTH       = 8,
  parameter int LEN_W       = 16,
  parameter int DEFAULT_LEN = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in_port,
  output logic [WIDTH-1:0]  tp_out,
  tp_pulse_stretcher_if.slave bus
);
  logic             wr;
  logic [WIDTH-1:0] mask_q, mask_d, flags_q, flags_d, in_d_q, rise, w1c;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      rdata;
  logic             unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign rise         = in_port & ~in_d_q;
  assign unused_wdata = ^bus.writedata[31:LEN_W];

  always_comb begin
    mask_d  = mask_q;
    len_d   = len_q;
    w1c     = (wr && bus.address == 3'd2) ? bus.writedata[WIDTH-1:0] : '0;
    // Rise wins over a same-cycle clear.
    flags_d = (flags_q & ~w1c) | rise;
    if (wr && bus.address == 3'd0) mask_d = bus.writedata[WIDTH-1:0];
    if (wr && bus.address == 3'd1) len_d  = bus.writedata[LEN_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q  <= '0;
      len_q   <= LEN_W'(DEFAULT_LEN);
      flags_q <= '0;
      in_d_q  <= '0;
    end else begin
      mask_q  <= mask_d;
      len_q   <= len_d;
      flags_q <= flags_d;
      in_d_q  <= in_port;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    tp_ch #(.LEN_W(LEN_W)) u_ch (
      .clk    (clk),
      .reset  (reset),
      .in_bit (in_port[i]),
      .in_d   (in_d_q[i]),
      .mask   (mask_q[i]),
      .len    (len_q),
      .tp_q   (tp_out[i])
    );
  end

`ifdef TP_STRETCH_EVCNT_EN
  logic [7:0][7:0] ev_q, ev_d;
  logic [7:0]      rise8;

  assign rise8 = 8'(rise);

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      ev_d[i] = ev_q[i];
      // Clear dominates a same-cycle rise.
      if (wr && bus.address == ((i < 4) ? 3'd4 : 3'd5)) ev_d[i] = '0;
      else if (rise8[i] && ev_q[i] != 8'hff)               ev_d[i] = ev_q[i] + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ev_q <= '0;
    else       ev_q <= ev_d;
  end
`endif

  always_comb begin
    rdata = '0;
    case (bus.address)
      3'd0: rdata = 32'(mask_q);
      3'd1: rdata = 32'(len_q);
      3'd2: rdata = 32'(flags_q);
`ifdef TP_STRETCH_EVCNT_EN
      3'd4: rdata = {ev_q[3], ev_q[2], ev_q[1], ev_q[0]};
      3'd5: rdata = {ev_q[7], ev_q[6], ev_q[5], ev_q[4]};
`endif
      default: rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;
endmodule
